cnt_lsz_gen: RTL and testbench

//  Parametrised enabled counter: the index generator for the Sobol RNG.

---
 rtl/cnt_lsz_gen.sv | 86 ++++++++
 tb/tb_cnt_lsz_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cnt_lsz_gen.sv
// cnt_lsz_gen: enabled up-counter used as the Sobol index generator.
// Supports wrap / saturate / one-shot end-of-count behaviour, synchronous
// clear and parallel load, and a least-significant-zero (LSZ) index that
// the Sobol stage uses to pick its direction vector every cycle.
//
// Control priority at each rising edge: rst > clear > load > enable > hold.
// Only cntOut and done are registered; lszOut, lszValid and tc are
// combinational, so they are valid in the same cycle as the count.
module cnt_lsz_gen #(
   parameter int CNTWD = 8,              // counter width, 2..32
   parameter int MODE  = 0,              // 0 = WRAP, 1 = SATURATE, 2 = ONESHOT
   parameter int LSZWD = $clog2(CNTWD)   // derived width of lszOut
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [CNTWD-1:0] loadVal,
   output logic [CNTWD-1:0] cntOut,
   output logic [LSZWD-1:0] lszOut,
   output logic             lszValid,
   output logic             tc,
   output logic             done
);

   localparam int MODE_WRAP    = 0;
   localparam int MODE_ONESHOT = 2;

   localparam logic [CNTWD-1:0] CNT_MAX = '1;
   localparam logic [CNTWD-1:0] CNT_ONE = CNTWD'(1);

   logic at_max;
   logic advance;

   assign at_max = (cntOut == CNT_MAX);

   // An enable only counts when nothing of higher priority is active and a
   // finished one-shot has not latched done (done stays 0 in other modes).
   assign advance = enable & ~rst & ~clear & ~load & ~done;

   // Terminal count: an accepted enable while sitting at MAX.
   assign tc = advance & at_max;

   // Count and done registers with the documented priority chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         cntOut <= '0;
         done   <= 1'b0;
      end else if (clear) begin
         cntOut <= '0;
         done   <= 1'b0;
      end else if (load) begin
         // Loading MAX in one-shot mode deliberately leaves done clear; the
         // next enable is what finishes the shot.
         cntOut <= loadVal;
         done   <= 1'b0;
      end else if (enable && !done) begin
         if (!at_max) begin
            cntOut <= cntOut + CNT_ONE;
         end else if (MODE == MODE_WRAP) begin
            cntOut <= '0;
         end else if (MODE == MODE_ONESHOT) begin
            done   <= 1'b1;
         end
         // SATURATE at MAX: hold.
      end
   end

   // Priority encoder for the lowest zero bit. Scanning from the top down
   // lets the lowest zero overwrite any higher one. While rst is asserted the
   // outputs are forced to the reset-state values.
   always_comb begin
      lszOut   = '0;
      lszValid = 1'b1;
      if (!rst) begin
         lszValid = ~at_max;
         for (int i = CNTWD - 1; i >= 0; i--) begin
            if (!cntOut[i]) begin
               lszOut = LSZWD'(i);
            end
         end
      end
   end

endmodule

// File: tb/tb_cnt_lsz_gen.sv
// Directed testbench for cnt_lsz_gen at CNTWD=4. Three instances (WRAP,
// SATURATE, ONESHOT) share one set of control inputs; each scenario checks
// the instance whose mode it exercises. Inputs change 1 ns after a rising
// edge; registered outputs are sampled there, combinational tc/lsz outputs
// are sampled after the new inputs have settled and before the next edge.
module tb_cnt_lsz_gen;

   localparam int W  = 4;
   localparam int LW = 2;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          clear;
   logic          load;
   logic [W-1:0]  loadVal;

   logic [W-1:0]  cnt_w, cnt_s, cnt_o;
   logic [LW-1:0] lsz_w, lsz_s, lsz_o;
   logic          lv_w, lv_s, lv_o;
   logic          tc_w, tc_s, tc_o;
   logic          done_w, done_s, done_o;

   int            n_checks;
   int            n_fail;
   int            tc_pulses;
   logic [LW-1:0] exp_q[$];

   cnt_lsz_gen #(.CNTWD(W), .MODE(0)) u_wrap (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
      .loadVal(loadVal), .cntOut(cnt_w), .lszOut(lsz_w), .lszValid(lv_w),
      .tc(tc_w), .done(done_w)
   );

   cnt_lsz_gen #(.CNTWD(W), .MODE(1)) u_sat (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
      .loadVal(loadVal), .cntOut(cnt_s), .lszOut(lsz_s), .lszValid(lv_s),
      .tc(tc_s), .done(done_s)
   );

   cnt_lsz_gen #(.CNTWD(W), .MODE(2)) u_one (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
      .loadVal(loadVal), .cntOut(cnt_o), .lszOut(lsz_o), .lszValid(lv_o),
      .tc(tc_o), .done(done_o)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Checking task: every comparison goes through here.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic drive(input logic r, input logic en, input logic clr,
                        input logic ld, input logic [W-1:0] lv);
      rst     = r;
      enable  = en;
      clear   = clr;
      load    = ld;
      loadVal = lv;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference LSZ for a 4-bit count (used only for the expected queue).
   function automatic logic [LW-1:0] ref_lsz(input int v);
      for (int i = 0; i < W; i++)
         if (((v >> i) & 1) == 0) return LW'(i);
      return '0;
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      step();

      // 1 Reset overrides enable/load, and mid-count.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
      for (int k = 0; k < 2; k++) begin
         step();
         check("rst_cnt", cnt_w, 0);
         check("rst_done", done_o, 0);
         check("rst_tc", tc_o, 0);
         check("rst_lsz", lsz_w, 0);
         check("rst_lszvalid", lv_w, 1);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
      step();
      check("load6_cnt", cnt_w, 6);
      drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      step();
      check("rst_mid_cnt", cnt_w, 0);

      // 2 WRAP, enable held for 17 edges.
      for (int k = 0; k < 15; k++) exp_q.push_back(ref_lsz(k));
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 17; k++) begin
         check("wrap_cnt", cnt_w, k % 16);
         check("wrap_tc", tc_w, (k % 16) == 15);
         if ((k % 16) == 15) begin
            check("wrap_lszvalid15", lv_w, 0);
            check("wrap_lsz15", lsz_w, 0);
         end else begin
            check("wrap_lszvalid", lv_w, 1);
            if (exp_q.size() > 0) check("wrap_lsz", lsz_w, exp_q.pop_front());
         end
         step();
      end
      check("wrap_after17", cnt_w, 1);
      check("wrap_done0", done_w, 0);

      // 3 Enable gating from 0.
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
      step();
      check("clr_cnt", cnt_w, 0);
      check("clr_done_one", done_o, 0);
      begin
         logic [4:0] en_pat;
         int         exp_cnt[5];
         en_pat     = 5'b11001;   // bit k = enable at edge k
         exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 2; exp_cnt[4] = 3;
         for (int k = 0; k < 5; k++) begin
            drive(1'b0, en_pat[k], 1'b0, 1'b0, '0);
            step();
            check("gate_cnt", cnt_w, exp_cnt[k]);
         end
      end

      // 4 Priority: load beats enable; clear beats load.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'hB);
      check("prio_load_tc", tc_w, 0);
      step();
      check("prio_load_cnt", cnt_w, 4'hB);
      check("prio_load_lsz", lsz_w, 2);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h7);
      step();
      check("prio_clear_cnt", cnt_w, 0);

      // 5 ONESHOT from 14, enable held 4 edges.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd14);
      step();
      check("one_load14", cnt_o, 14);
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      tc_pulses = 0;
      for (int k = 0; k < 4; k++) begin
         check("one_tc", tc_o, k == 1);
         if (tc_o) tc_pulses++;
         step();
         check("one_cnt", cnt_o, 15);
         check("one_done", done_o, k >= 1);
      end
      check("one_tc_pulses", tc_pulses, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      step();
      check("one_reload_cnt", cnt_o, 3);
      check("one_reload_done", done_o, 0);
      // Loading MAX does not finish the shot; the next enable does.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
      step();
      check("one_loadmax_done", done_o, 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("one_loadmax_tc", tc_o, 1);
      step();
      check("one_loadmax_done2", done_o, 1);
      check("one_loadmax_cnt", cnt_o, 15);

      // 6 SATURATE from 13, enable held 5 edges.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
      step();
      check("sat_load13", cnt_s, 13);
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      begin
         int exp_s[5];
         exp_s[0] = 14; exp_s[1] = 15; exp_s[2] = 15; exp_s[3] = 15; exp_s[4] = 15;
         for (int k = 0; k < 5; k++) begin
            check("sat_tc", tc_s, k >= 2);
            step();
            check("sat_cnt", cnt_s, exp_s[k]);
            check("sat_done", done_s, 0);
         end
      end
      // The WRAP instance saw the same stimulus and must have rolled over.
      check("wrap_roll", cnt_w, 2);

      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
